serial_add_ctrl: RTL and testbench

- Bit-serial adder controller built around a single existing one-bit full-adder cell (fulladd).
- Latches two WIDTH-bit operands and feeds them through the cell LSB-first, one bit per clock, keeping the carry in a flip-flop.
- Assembles the sum and raises a one-cycle done pulse.
- Serves as the area-minimal arithmetic engine for the BCD/arithmetic blocks when throughput is not critical.

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/fulladd.sv | 13 +
 rtl/serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_serial_add_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // One spare bit over $clog2 so the counter can never wrap mid-operation.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fulladd.sv
// One-bit full-adder cell shared by the serial arithmetic blocks.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: LSB-first through one fulladd cell, WIDTH+2 cycles per operation.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             b_bit, load_carry;
  logic             fa_s, fa_co;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      sub_r <= 1'b0;
    else if (state == IDLE && start) sub_r <= sub;
  end

  // Two's-complement subtract: invert B and force the initial carry to 1.
  assign b_bit      = b_sh[0] ^ sub_r;
  assign load_carry = sub ? 1'b1 : cin;
`else
  assign b_bit      = b_sh[0];
  assign load_carry = cin;
`endif

  fulladd u_fa (
    .a  (a_sh[0]),
    .b  (b_bit),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh   <= op_a;
          b_sh   <= op_b;
          res_sh <= '0;
          carry  <= load_carry;
          cnt    <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {fa_s, res_sh[WIDTH-1:1]};
          carry  <= fa_co;
          cnt    <= cnt + 1'b1;
          // Last bit: carry still holds the carry into the MSB, so ovf is formed here.
          if (cnt == LAST) begin
            sum  <= {fa_s, res_sh[WIDTH-1:1]};
            cout <= fa_co;
            ovf  <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8); subtract vectors run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, cin;
  logic [W-1:0] op_a, op_b, sum;
  logic         busy, done, cout, ovf;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ci, input logic sb, input logic [W-1:0] s,
                              input logic co, input logic ov);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.ci = ci; v.sb = sb;
    v.s = s; v.co = co; v.ov = ov;
    return v;
  endfunction

  // Entered and left on a negedge with the DUT idle.
  task automatic run_op(input vec_t v);
    int unsigned n      = 1;
    int unsigned busy_n = 0;
    bit          seen   = 0;
    op_a  = v.a;
    op_b  = v.b;
    cin   = v.ci;
`ifdef SERIAL_ADD_SUB_EN
    sub   = v.sb;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!seen && n < 40) begin
      if (done) seen = 1;
      else begin
        if (busy) busy_n++;
        @(negedge clk);
        n++;
      end
    end
    check({v.name, "_done_seen"}, 32'(seen), 32'd1);
    check({v.name, "_latency"},   n,         32'd9);
    check({v.name, "_busy_cycles"}, busy_n,  32'd8);
    check({v.name, "_sum"},  32'(sum),  32'(v.s));
    check({v.name, "_cout"}, 32'(cout), 32'(v.co));
    check({v.name, "_ovf"},  32'(ovf),  32'(v.ov));
    @(negedge clk);
    check({v.name, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int unsigned done_cnt;
    logic [W-1:0] cap_sum;
    logic [W-1:0] b2b_a[3];
    logic [W-1:0] b2b_b[3];
    logic [W-1:0] b2b_s[3];
    int unsigned  idx[3];
    int unsigned  k;
    bit           stable_err;
    logic [W-1:0] last_sum;

    //               name        a      b      ci    sb    sum    co    ov
    vecs.push_back(mk("add_3c_05", 8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0));
    vecs.push_back(mk("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0));
    vecs.push_back(mk("add_7f_ci", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1));
    vecs.push_back(mk("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1));
    vecs.push_back(mk("add_aa_55", 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0));
    vecs.push_back(mk("add_64_64", 8'h64, 8'h64, 1'b0, 1'b0, 8'hC8, 1'b0, 1'b1));
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back(mk("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0));
    vecs.push_back(mk("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0));
    vecs.push_back(mk("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1));
    vecs.push_back(mk("sub_05_03", 8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0));
    vecs.push_back(mk("add_sub0",  8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1));
`endif

    rst_n = 1'b0; start = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

    // Second start during RUN must be ignored.
    op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op_a = 8'hAA; op_b = 8'h55; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    cap_sum  = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        done_cnt++;
        cap_sum = sum;
      end
      @(negedge clk);
    end
    check("ignored_start_done_count", done_cnt, 32'd1);
    check("ignored_start_sum", 32'(cap_sum), 32'h46);

    // Reset in the middle of RUN aborts the operation.
    op_a = 8'h80; op_b = 8'h80; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("abort_no_done", done_cnt, 32'd0);
    run_op(mk("after_abort", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0));

    // Back-to-back with start held high.
    b2b_a[0] = 8'h11; b2b_b[0] = 8'h22; b2b_s[0] = 8'h33;
    b2b_a[1] = 8'h40; b2b_b[1] = 8'h05; b2b_s[1] = 8'h45;
    b2b_a[2] = 8'hF0; b2b_b[2] = 8'h0F; b2b_s[2] = 8'hFF;
    op_a = b2b_a[0]; op_b = b2b_b[0]; cin = 1'b0; start = 1'b1;
    k = 0;
    stable_err = 0;
    last_sum = sum;
    idx[0] = 0; idx[1] = 0; idx[2] = 0;
    for (int unsigned t = 0; t < 60 && k < 3; t++) begin
      @(negedge clk);
      if (done) begin
        idx[k] = t;
        check($sformatf("b2b_sum_%0d", k), 32'(sum), 32'(b2b_s[k]));
        last_sum = sum;
        k++;
        if (k < 3) begin
          op_a = b2b_a[k];
          op_b = b2b_b[k];
        end else start = 1'b0;
      end else if (sum !== last_sum) stable_err = 1;
    end
    start = 1'b0;
    check("b2b_op_count", k, 32'd3);
    check("b2b_period_1", idx[1] - idx[0], 32'd10);
    check("b2b_period_2", idx[2] - idx[1], 32'd10);
    check("b2b_sum_stable", 32'(stable_err), 32'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
